display_scan: RTL and testbench

DISPLAY_SCAN -- requirements
Module: display_scan

---
 rtl/display_pkg.sv | 27 ++
 rtl/display_scan_if.sv | 28 ++
 rtl/display_scan_seg_decode.sv | 23 ++
 rtl/display_scan.sv | 152 +++++++++++++++
 tb/tb_display_scan.sv | 194 +++++++++++++++++++
 5 files changed

// File: rtl/display_pkg.sv
// Shared constants, FSM state type and seven-segment pattern table for the display scanner.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package display_pkg;

  localparam int ROWS   = 8;
  localparam int DIGITS = 8;
  localparam int IDX_W  = 3;
  localparam int MAT_W  = 2 * ROWS * 8;
  localparam int NUM_W  = 4 * DIGITS;

  typedef enum logic {
    BLANK = 1'b0,
    DRIVE = 1'b1
  } scan_state_t;

  // Active-low {dp,g,f,e,d,c,b,a}; entry 0 is the rightmost element.
  localparam logic [15:0][7:0] SEG_TABLE = {
    8'h8E, 8'h86, 8'hA1, 8'hC6, 8'h83, 8'h88, 8'h90, 8'h80,
    8'hF8, 8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hC0
  };

  function automatic logic [7:0] seg_pattern(input logic [3:0] nib);
    return SEG_TABLE[nib];
  endfunction

endpackage

// File: rtl/display_scan_if.sv
// Frame inputs and multiplexed LED matrix / seven-segment drive outputs.
// Latency: none (wiring only).
// Backpressure: none; frame data is sampled whenever the scanner starts a frame.
interface display_scan_if;
  import display_pkg::*;

  logic [MAT_W-1:0]  matrixData;
  logic [NUM_W-1:0]  numbersData;
  logic [ROWS-1:0]   row_n;
  logic [7:0]        col_r;
  logic [7:0]        col_g;
  logic [DIGITS-1:0] dig_n;
  logic [7:0]        seg_n;
  logic              frame_start;

  // The scanner consumes frame data and drives the display.
  modport master (
    input  matrixData, numbersData,
    output row_n, col_r, col_g, dig_n, seg_n, frame_start
  );

  // The frame source / display side.
  modport slave (
    output matrixData, numbersData,
    input  row_n, col_r, col_g, dig_n, seg_n, frame_start
  );

endinterface

// File: rtl/display_scan_seg_decode.sv
// Hex nibble to active-low seven-segment pattern; dp always off. HEX_F_BLANK_EN darkens 4'hF.
// Latency: combinational.
// Backpressure: none.
module seg_decode
  import display_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [7:0] seg_n
);

  // Table lookup, with 4'hF optionally used as a "digit off" code.
  always_comb begin
    seg_n = seg_pattern(nibble);
`ifdef HEX_F_BLANK_EN
    if (nibble == 4'hF) begin
      seg_n = 8'hFF;
    end
`else
    seg_n[7] = 1'b1;
`endif
  end

endmodule

// File: rtl/display_scan.sv
// Time-multiplexed scan of an 8x8 bicolor matrix and 8 hex digits sharing one slot index; optional HEX_F_BLANK_EN.
// Latency: inputs snapshot at frame start; visible up to 8 slots + BLANK_CYC clocks later; outputs registered.
// Backpressure: none; free-running scan, mid-frame input changes wait for the next frame.
module display_scan
  import display_pkg::*;
#(
  parameter int CLK_FREQ  = 50_000_000,
  parameter int SCAN_HZ   = 1000,
  parameter int BLANK_CYC = 16
) (
  input  logic          clk,
  input  logic          sw,
  display_scan_if.master disp
);

  localparam int TICK  = CLK_FREQ / SCAN_HZ;
  localparam int CNT_W = (TICK > 1) ? $clog2(TICK) : 1;
  localparam int BLK_W = (BLANK_CYC > 1) ? $clog2(BLANK_CYC) : 1;

  logic [CNT_W-1:0] tick_cnt;
  logic             tick;
  scan_state_t      state, state_nxt;
  logic [BLK_W-1:0] blank_cnt;
  logic             advance;
  logic             wrap;
  logic [IDX_W-1:0] slot;
  logic [MAT_W-1:0] snap_mat;
  logic [NUM_W-1:0] snap_num;
  logic [3:0]       cur_nib;
  logic [7:0]       cur_seg;
  logic [7:0]       row_r;
  logic [7:0]       row_g;

  assign tick = (tick_cnt == CNT_W'(TICK - 1));
  assign wrap = advance && (slot == IDX_W'(ROWS - 1));

  // Free-running slot timer; a tick marks the last clock of a slot.
  always_ff @(posedge clk or negedge sw) begin
    if (!sw) begin
      tick_cnt <= '0;
    end else if (tick) begin
      tick_cnt <= '0;
    end else begin
      tick_cnt <= tick_cnt + 1'b1;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge sw) begin
    if (!sw) begin
      state <= BLANK;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state: blank for BLANK_CYC clocks after every slot change, then drive until the tick.
  always_comb begin
    state_nxt = state;
    advance   = 1'b0;
    case (state)
      BLANK: begin
        if (blank_cnt == BLK_W'(BLANK_CYC - 1)) begin
          state_nxt = DRIVE;
        end
      end
      DRIVE: begin
        if (tick) begin
          state_nxt = BLANK;
          advance   = 1'b1;
        end
      end
      default: state_nxt = BLANK;
    endcase
  end

  // Counts clocks spent in the current blanking interval.
  always_ff @(posedge clk or negedge sw) begin
    if (!sw) begin
      blank_cnt <= '0;
    end else if (state == BLANK && state_nxt == BLANK) begin
      blank_cnt <= blank_cnt + 1'b1;
    end else begin
      blank_cnt <= '0;
    end
  end

  // Slot index; parks at 7 in reset so the first tick starts a frame at slot 0.
  always_ff @(posedge clk or negedge sw) begin
    if (!sw) begin
      slot <= IDX_W'(ROWS - 1);
    end else if (advance) begin
      slot <= slot + 1'b1;
    end
  end

  // Frame snapshot and frame_start pulse, both on the clock the index wraps to 0.
  always_ff @(posedge clk or negedge sw) begin
    if (!sw) begin
      snap_mat         <= '0;
      snap_num         <= '0;
      disp.frame_start <= 1'b0;
    end else begin
      disp.frame_start <= wrap;
      if (wrap) begin
        snap_mat <= disp.matrixData;
        snap_num <= disp.numbersData;
      end
    end
  end

  // Pick the current row's red/green bits out of the snapshot; pixel p = row*8+col.
  always_comb begin
    row_r = '0;
    row_g = '0;
    for (int c = 0; c < 8; c++) begin
      row_r[c] = snap_mat[{slot, 3'(c), 1'b1}];
      row_g[c] = snap_mat[{slot, 3'(c), 1'b0}];
    end
  end

  assign cur_nib = snap_num[{slot, 2'b00} +: 4];

  seg_decode u_seg_decode (
    .nibble (cur_nib),
    .seg_n  (cur_seg)
  );

  // Registered drive: matrix row and digit lit together while the next state is DRIVE, else all dark.
  always_ff @(posedge clk or negedge sw) begin
    if (!sw) begin
      disp.row_n <= '1;
      disp.col_r <= '0;
      disp.col_g <= '0;
      disp.dig_n <= '1;
      disp.seg_n <= 8'hFF;
    end else if (state_nxt == DRIVE) begin
      disp.row_n <= ~(ROWS'(1) << slot);
      disp.col_r <= row_r;
      disp.col_g <= row_g;
      disp.dig_n <= ~(DIGITS'(1) << slot);
      disp.seg_n <= cur_seg;
    end else begin
      disp.row_n <= '1;
      disp.col_r <= '0;
      disp.col_g <= '0;
      disp.dig_n <= '1;
      disp.seg_n <= 8'hFF;
    end
  end

endmodule

// File: tb/tb_display_scan.sv
// Directed bench for display_scan with TICK=8, BLANK_CYC=2; honours HEX_F_BLANK_EN.
// Latency: checks every clock of each frame against a slot/phase model.
// Backpressure: none.
module tb_display_scan;

  logic clk = 1'b0;
  logic sw;
  int   errors = 0;
  int   checks = 0;

  localparam logic [127:0] MAT_RED = {64{2'b10}};
  localparam logic [127:0] MAT_B   = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
  localparam logic [127:0] MAT_C   = 128'hFFFF_0000_AAAA_5555_0F0F_F0F0_3C3C_C3C3;
  localparam logic [31:0]  NUM_A   = 32'h0888_8888;
  localparam logic [31:0]  NUM_B   = 32'hFEDC_BA98;
  localparam logic [31:0]  NUM_F   = 32'hFFFF_FFFF;
  localparam logic [31:0]  NUM_C   = 32'h7654_3210;
  localparam logic [40:0]  BLANK_VEC = {8'hFF, 8'h00, 8'h00, 8'hFF, 8'hFF, 1'b0};

  display_scan_if disp ();

  display_scan #(
    .CLK_FREQ  (8),
    .SCAN_HZ   (1),
    .BLANK_CYC (2)
  ) dut (
    .clk  (clk),
    .sw   (sw),
    .disp (disp)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] seg_ref(input logic [3:0] n);
    case (n)
      4'h0: return 8'hC0;
      4'h1: return 8'hF9;
      4'h2: return 8'hA4;
      4'h3: return 8'hB0;
      4'h4: return 8'h99;
      4'h5: return 8'h92;
      4'h6: return 8'h82;
      4'h7: return 8'hF8;
      4'h8: return 8'h80;
      4'h9: return 8'h90;
      4'hA: return 8'h88;
      4'hB: return 8'h83;
      4'hC: return 8'hC6;
      4'hD: return 8'hA1;
      4'hE: return 8'h86;
`ifdef HEX_F_BLANK_EN
      default: return 8'hFF;
`else
      default: return 8'h8E;
`endif
    endcase
  endfunction

  // Expected {row_n,col_r,col_g,dig_n,seg_n,frame_start} t clocks after the frame_start edge.
  function automatic logic [40:0] expect_vec(input int t, input logic [127:0] m, input logic [31:0] n);
    int s;
    int p;
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] sel;
    s = t / 8;
    p = t % 8;
    if (p < 2) return {8'hFF, 8'h00, 8'h00, 8'hFF, 8'hFF, (t == 0)};
    for (int c = 0; c < 8; c++) begin
      r[c] = m[2 * (s * 8 + c) + 1];
      g[c] = m[2 * (s * 8 + c)];
    end
    sel = ~(8'b1 << s);
    return {sel, r, g, sel, seg_ref(n[4 * s +: 4]), 1'b0};
  endfunction

  function automatic logic [40:0] observed();
    return {disp.row_n, disp.col_r, disp.col_g, disp.dig_n, disp.seg_n, disp.frame_start};
  endfunction

  // Checks one full 64-clock frame; optionally changes the inputs after clock chg_t.
  task automatic check_frame(input string name, input logic [127:0] m, input logic [31:0] n,
                             input int chg_t, input logic [127:0] m2, input logic [31:0] n2);
    logic [40:0] obs;
    logic [40:0] exp_v;
    for (int t = 0; t < 64; t++) begin
      @(negedge clk);
      obs   = observed();
      exp_v = expect_vec(t, m, n);
      checks++;
      if (obs !== exp_v) begin
        errors++;
        $display("FAIL %s t=%0d got=%h expected=%h", name, t, obs, exp_v);
      end
      if (t == chg_t) begin
        disp.matrixData  = m2;
        disp.numbersData = n2;
      end
    end
  endtask

  // Releases reset at a negedge; no frame_start may appear before the first tick.
  task automatic release_reset(input string name);
    sw = 1'b1;
    for (int k = 1; k < 8; k++) begin
      @(negedge clk);
      checks++;
      if (disp.frame_start !== 1'b0) begin
        errors++;
        $display("FAIL %s early frame_start clk=%0d got=%b expected=0", name, k, disp.frame_start);
      end
    end
  endtask

  task automatic test_reset();
    sw               = 1'b0;
    disp.matrixData  = '0;
    disp.numbersData = '0;
    repeat (3) @(negedge clk);
    checks++;
    if (disp.row_n !== 8'hFF) begin errors++; $display("FAIL reset row_n got=%h expected=ff", disp.row_n); end
    checks++;
    if (disp.col_r !== 8'h00) begin errors++; $display("FAIL reset col_r got=%h expected=00", disp.col_r); end
    checks++;
    if (disp.col_g !== 8'h00) begin errors++; $display("FAIL reset col_g got=%h expected=00", disp.col_g); end
    checks++;
    if (disp.dig_n !== 8'hFF) begin errors++; $display("FAIL reset dig_n got=%h expected=ff", disp.dig_n); end
    checks++;
    if (disp.seg_n !== 8'hFF) begin errors++; $display("FAIL reset seg_n got=%h expected=ff", disp.seg_n); end
    checks++;
    if (disp.frame_start !== 1'b0) begin errors++; $display("FAIL reset frame_start got=%b expected=0", disp.frame_start); end
  endtask

  task automatic test_first_frame();
    disp.matrixData  = MAT_RED;
    disp.numbersData = NUM_A;
    release_reset("first");
    check_frame("first_frame", MAT_RED, NUM_A, -1, MAT_RED, NUM_A);
  endtask

  task automatic test_mid_frame_change();
    check_frame("old_frame_held", MAT_RED, NUM_A, 26, MAT_B, NUM_B);
    check_frame("new_frame", MAT_B, NUM_B, -1, MAT_B, NUM_B);
  endtask

  task automatic test_all_f();
    check_frame("before_all_f", MAT_B, NUM_B, 0, MAT_B, NUM_F);
    check_frame("all_f", MAT_B, NUM_F, -1, MAT_B, NUM_F);
  endtask

  task automatic test_reset_mid_slot();
    logic [40:0] obs;
    logic [40:0] exp_v;
    for (int t = 0; t < 44; t++) @(negedge clk);
    obs   = observed();
    exp_v = expect_vec(43, MAT_B, NUM_F);
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL slot5_drive got=%h expected=%h", obs, exp_v);
    end
    #2 sw = 1'b0;
    #1;
    obs = observed();
    checks++;
    if (obs !== BLANK_VEC) begin
      errors++;
      $display("FAIL async_blank got=%h expected=%h", obs, BLANK_VEC);
    end
    @(negedge clk);
    disp.matrixData  = MAT_C;
    disp.numbersData = NUM_C;
    @(negedge clk);
    obs = observed();
    checks++;
    if (obs !== BLANK_VEC) begin
      errors++;
      $display("FAIL held_blank got=%h expected=%h", obs, BLANK_VEC);
    end
    release_reset("restart");
    check_frame("restart_frame", MAT_C, NUM_C, -1, MAT_C, NUM_C);
  endtask

  initial begin
    test_reset();
    test_first_frame();
    test_mid_frame_change();
    test_all_f();
    test_reset_mid_slot();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
